// File: rtl/whack_scorer.sv
// Whack-a-mole scoring stage: judges button presses against the mole position, keeps BCD score/misses.
// Optional macro WHACK_TIMEOUT_MISS_EN: an escaped (unhit) mole also counts as a miss.
module whack_scorer #(
    parameter int MAX_MISSES = 3
) (
    input  logic       i_clk,
    input  logic       i_restart_game,
    input  logic [4:0] i_buttons,
    input  logic [2:0] i_mole_position,
    input  logic       i_position_changed,
    output logic       o_change_position,
    output logic       o_hit,
    output logic [3:0] o_score_ones,
    output logic [3:0] o_score_tens,
    output logic [1:0] o_misses,
    output logic       o_game_over
);

    typedef enum logic [1:0] {WAIT_MOLE, ARMED, HIT_WAIT, OVER} state_t;

    localparam logic [1:0] MAX_M = 2'(MAX_MISSES);

    state_t     state, state_nxt;
    logic [4:0] btn_prev, press, mole_mask;
    logic       hit_q, miss_q, chg_q;
    logic       hit_r, hit_nxt;
    logic [3:0] ones_nxt, tens_nxt;
    logic [1:0] misses_nxt, misses_inc;

    // Positions 5..7 shift the bit out, so no single-bit press can match them.
    assign mole_mask  = 5'd1 << i_mole_position;
    assign press      = i_buttons & ~btn_prev;
    assign misses_inc = o_misses + 2'd1;

    assign o_hit             = hit_r;
    assign o_change_position = hit_r;

    // Press classification and strobe are registered first; the FSM acts one edge later.
    always_ff @(posedge i_clk) begin
        btn_prev <= i_buttons;
        if (i_restart_game) begin
            hit_q  <= 1'b0;
            miss_q <= 1'b0;
            chg_q  <= 1'b0;
        end else begin
            hit_q  <= (press != 5'd0) && (press == mole_mask);
            miss_q <= (press != 5'd0) && (press != mole_mask);
            chg_q  <= i_position_changed;
        end
    end

    always_comb begin
        state_nxt  = state;
        hit_nxt    = 1'b0;
        ones_nxt   = o_score_ones;
        tens_nxt   = o_score_tens;
        misses_nxt = o_misses;
        case (state)
            WAIT_MOLE: if (chg_q) state_nxt = ARMED;
            ARMED: begin
                if (chg_q) begin
`ifdef WHACK_TIMEOUT_MISS_EN
                    misses_nxt = misses_inc;
                    if (misses_inc == MAX_M) state_nxt = OVER;
`endif
                end else if (hit_q) begin
                    hit_nxt   = 1'b1;
                    state_nxt = HIT_WAIT;
                    if (!(o_score_ones == 4'd9 && o_score_tens == 4'd9)) begin
                        if (o_score_ones == 4'd9) begin
                            ones_nxt = 4'd0;
                            tens_nxt = o_score_tens + 4'd1;
                        end else begin
                            ones_nxt = o_score_ones + 4'd1;
                        end
                    end
                end else if (miss_q) begin
                    misses_nxt = misses_inc;
                    if (misses_inc == MAX_M) state_nxt = OVER;
                end
            end
            HIT_WAIT:  if (chg_q) state_nxt = ARMED;
            default:   state_nxt = OVER;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_restart_game) begin
            state        <= WAIT_MOLE;
            hit_r        <= 1'b0;
            o_score_ones <= 4'd0;
            o_score_tens <= 4'd0;
            o_misses     <= 2'd0;
            o_game_over  <= 1'b0;
        end else begin
            state        <= state_nxt;
            hit_r        <= hit_nxt;
            o_score_ones <= ones_nxt;
            o_score_tens <= tens_nxt;
            o_misses     <= misses_nxt;
            o_game_over  <= (state_nxt == OVER);
        end
    end

endmodule

// File: tb/tb_whack_scorer.sv
// Directed bench for whack_scorer: hits, misses, game over, saturation, strobe priority, mid-game reset.
module tb_whack_scorer;

    logic       clk = 1'b0;
    logic       restart;
    logic [4:0] buttons;
    logic [2:0] mole_pos;
    logic       pos_chg;
    logic       change_pos, hit, game_over;
    logic [3:0] ones, tens;
    logic [1:0] misses;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    whack_scorer #(.MAX_MISSES(3)) dut (
        .i_clk              (clk),
        .i_restart_game     (restart),
        .i_buttons          (buttons),
        .i_mole_position    (mole_pos),
        .i_position_changed (pos_chg),
        .o_change_position  (change_pos),
        .o_hit              (hit),
        .o_score_ones       (ones),
        .o_score_tens       (tens),
        .o_misses           (misses),
        .o_game_over        (game_over)
    );

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One-cycle strobe; after return the scorer has taken it into account.
    task automatic strobe(input logic [2:0] pos);
        mole_pos = pos;
        pos_chg  = 1'b1;
        tick();
        pos_chg  = 1'b0;
        tick();
    endtask

    // Press edge then release; after return the resulting pulse/score is visible.
    task automatic press(input logic [4:0] b);
        buttons = b;
        tick();
        buttons = 5'd0;
        tick();
    endtask

    task automatic chk_all(input string tag, input int e_hit, input int e_score,
                           input int e_miss, input int e_over);
        chk({tag, ".hit"},   int'(hit), e_hit);
        chk({tag, ".chg"},   int'(change_pos), e_hit);
        chk({tag, ".ones"},  int'(ones), e_score % 10);
        chk({tag, ".tens"},  int'(tens), e_score / 10);
        chk({tag, ".miss"},  int'(misses), e_miss);
        chk({tag, ".over"},  int'(game_over), e_over);
    endtask

    initial begin
        int exp_to;
`ifdef WHACK_TIMEOUT_MISS_EN
        exp_to = 1;
`else
        exp_to = 0;
`endif
        restart  = 1'b1;
        buttons  = 5'b00100;
        mole_pos = 3'd5;
        pos_chg  = 1'b0;
        tick(2);
        restart = 1'b0;
        chk_all("reset", 0, 0, 0, 0);

        // Button held through reset gives no edge
        strobe(3'd2);
        tick();
        chk_all("held", 0, 0, 0, 0);
        buttons = 5'd0;
        tick();
        press(5'b00100);
        chk_all("hit1", 1, 1, 0, 0);
        tick();
        chk_all("hit1_end", 0, 1, 0, 0);

        // Press during HIT_WAIT is neither hit nor miss
        press(5'b00001);
        chk_all("hitwait", 0, 1, 0, 0);

        strobe(3'd3);
        press(5'b00010);
        chk_all("miss1", 0, 1, 1, 0);
        press(5'b10001);
        chk_all("miss2", 0, 1, 2, 0);
        press(5'b00001);
        chk_all("miss3", 0, 1, 3, 1);

        press(5'b01000);
        chk_all("over_press", 0, 1, 3, 1);
        strobe(3'd1);
        press(5'b00010);
        chk_all("over_strobe", 0, 1, 3, 1);

        restart = 1'b1;
        tick();
        restart = 1'b0;
        chk_all("restart", 0, 0, 0, 0);

        // Press edge coincident with a strobe in ARMED
        strobe(3'd0);
        buttons  = 5'b00001;
        mole_pos = 3'd1;
        pos_chg  = 1'b1;
        tick();
        buttons = 5'd0;
        pos_chg = 1'b0;
        tick();
        chk_all("coincide", 0, 0, exp_to, 0);

        // Reset asserted in HIT_WAIT returns to WAIT_MOLE with score cleared
        press(5'b00010);
        chk_all("hit_pre_rst", 1, 1, exp_to, 0);
        restart = 1'b1;
        tick();
        restart = 1'b0;
        chk_all("rst_hitwait", 0, 0, 0, 0);
        press(5'b00010);
        chk_all("wait_mole", 0, 0, 0, 0);

        // Score carry and saturation across 100 hits
        strobe(3'd4);
        for (int i = 1; i <= 100; i++) begin
            press(5'b10000);
            chk_all($sformatf("run%0d", i), 1, (i > 99) ? 99 : i, 0, 0);
            tick();
            strobe(3'd4);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/whack_scorer.md
# whack_scorer

Scoring and game-state stage directly downstream of the mole position generator. Consumes the current mole position and its change strobe, judges player button presses as hits or misses, and keeps a saturating BCD score and a miss count. Produces the change-position request and the game-over flag that feed back into the position generator, plus score digits for the display driver.

## Interface
- `MAX_MISSES`, default 3: misses that end the game; legal range 1–3.
- `i_clk`  input  1  system clock; all logic on the rising edge.
- `i_restart_game`  input  1  synchronous, active-high reset; restarts the game.
- `i_buttons`  input  5  debounced, level-sensitive player buttons; bit k is hole k.
- `i_mole_position`  input  3  current mole hole, 0–4; 5 means no mole shown yet.
- `i_position_changed`  input  1  one-cycle strobe; `i_mole_position` is already the new value in that cycle.
- `o_change_position`  output  1  one-cycle request for a new mole after a hit.
- `o_hit`  output  1  one-cycle hit pulse, for LED/sound.
- `o_score_ones`  output  4  BCD ones digit.
- `o_score_tens`  output  4  BCD tens digit.
- `o_misses`  output  2  miss count, 0..`MAX_MISSES`.
- `o_game_over`  output  1  high from the final miss until reset.

## Operation
- Press detection:
  - `btn_prev` register; `press = i_buttons & ~btn_prev`.
  - `btn_prev <= i_buttons` every cycle, including during reset, so buttons held through reset produce no edge.
- A press cycle is any cycle with `press != 0`. Classification:
  - Hit: exactly one bit set and its index equals `i_mole_position`.
  - Miss: any other pattern, including two or more bits set; counts as one miss.
- States: WAIT_MOLE (reset state), ARMED, HIT_WAIT, OVER.
- WAIT_MOLE:
  - Presses are ignored.
  - `i_position_changed` -> ARMED.
- ARMED:
  - `i_position_changed` takes priority. Any press in the same cycle is ignored. The mole has escaped (see Configuration). Stay in ARMED.
  - Otherwise, on a hit:
    - Increment the score, saturating at 99.
    - Pulse `o_hit` and `o_change_position`.
    - Go to HIT_WAIT.
  - Otherwise, on a miss:
    - Increment `o_misses`.
    - If the new count equals `MAX_MISSES`, go to OVER; else stay in ARMED.
- HIT_WAIT:
  - Presses are ignored.
  - `i_position_changed` -> ARMED.
- OVER:
  - `o_game_over = 1`; all inputs except reset are ignored.
  - Score and misses hold.
- Score arithmetic:
  - Ones digit wraps 9->0 with a carry into tens.
  - At 99, further hits still pulse `o_hit` and `o_change_position`, but the score stays 99.
- Reset:
  - All outputs 0, state WAIT_MOLE.
  - Mid-game reset (any state) takes effect at the next edge and overrides every other event in that cycle.

## Timing
- All outputs are registered.
- Press edge on `i_buttons` sampled at edge N:
  - `o_hit`, `o_change_position` and the updated score are visible after edge N+1.
  - `o_change_position` is high for exactly one cycle.
- The position generator answers with `i_position_changed` on the following edge. HIT_WAIT absorbs that round trip, so a second press in that window is neither a hit nor a miss.
- Final miss at edge N: `o_misses = MAX_MISSES` and `o_game_over = 1` both after edge N+1, same cycle.
- `o_game_over` feeds the generator's game-over input directly. No further `i_position_changed` is expected afterwards; any that arrive are ignored.

## Configuration
- `WHACK_TIMEOUT_MISS_EN` defined:
  - Each `i_position_changed` received in ARMED (mole escaped unhit) increments `o_misses`, with the same game-over rule as a wrong press.
- Not defined:
  - Escapes are silent; only wrong presses count as misses.

## Test plan
- Reset with `i_buttons = 5'b00100` held, then strobe position 2 -> no hit until the button is released and pressed again. Re-press -> `o_hit` one cycle, score 01, `o_change_position` one cycle.
- Position 3, press button 1, then buttons 0 and 4 together -> `o_misses` = 1, then 2. Score unchanged, no `o_change_position`.
- `MAX_MISSES = 3`, three wrong presses -> after the third, `o_game_over = 1` and `o_misses = 3`. Further presses and strobes change nothing. `i_restart_game` -> all outputs 0.
- 100 consecutive hits, each followed by a strobe -> score goes 09 -> 10 and 98 -> 99, then holds at 99. `o_hit` still pulses on every hit.
- Press edge coincident with `i_position_changed` in ARMED -> no hit or miss from the press. With `WHACK_TIMEOUT_MISS_EN`, `o_misses` = 1; without it, 0.
- Hit, then a second press before the strobe (HIT_WAIT) -> ignored. Reset asserted in HIT_WAIT -> WAIT_MOLE, score 00.
